// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int W_DEF  = 16;
    localparam int CW_DEF = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step1.sv
// Combinational single-position shifter: the one datapath step the sequencer iterates.
module shift_step1
    import shift_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] d,
    input  op_e          op,
    output logic [W-1:0] q
);

    always_comb begin
        // NOTE: q gets a value before the case so no path leaves it unassigned (no latch).
        q = d;
        unique case (op)
            OP_ROL: q = {d[W-2:0], d[W-1]};
            OP_SLL: q = {d[W-2:0], 1'b0};
            OP_ROR: q = {d[0], d[W-1:1]};
            OP_SRL: q = {1'b0, d[W-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift/rotate sequencer: one bit position per clock, valid/ready in and out,
// result held in DONE until consumed; abort and reset return to IDLE.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [CW-1:0] in_cnt,
    input  logic [1:0]    in_op,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] rem_q, rem_d;
    op_e           op_q, op_d;
    logic [W-1:0]  step_q;

    shift_step1 #(.W(W)) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_q)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_ROL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            ST_IDLE: begin
                // abort wins over a simultaneous request
                if (in_valid && !abort) begin
                    data_d  = in_data;
                    rem_d   = in_cnt;
                    op_d    = op_e'(in_op);
                    state_d = (in_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    data_d = step_q;
                    // leaves SHIFT at remaining==1, so the decrement never wraps
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (abort || out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed-vector bench for shift_seq_ctrl with hand-computed results and latencies.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_data);
        check({tag, ".out_valid"}, out_valid, 1'b0);
        check({tag, ".in_ready"},  in_ready,  1'b1);
        check({tag, ".busy"},      busy,      1'b0);
        check({tag, ".out_data"},  out_data,  exp_data);
    endtask

    // present one request for one edge, then count cycles until out_valid
    task automatic launch(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                          output int lat);
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
        tick();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_cnt   = 4'hF;
        in_op    = 2'b11;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] c,
                          input logic [1:0] op, input logic [15:0] exp_data, input int exp_lat);
        int lat;
        launch(d, c, op, lat);
        check({tag, ".latency"},  lat,       exp_lat);
        check({tag, ".out_data"}, out_data,  exp_data);
        check({tag, ".in_ready"}, in_ready,  1'b0);
        check({tag, ".busy"},     busy,      1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".consumed"}, out_valid, 1'b0);
        check({tag, ".idle"},     in_ready,  1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int  lat;
        bit  seen_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_idle("reset", 16'h0000);

        run_op("rol1",    16'h8001, 4'd1,  2'b00, 16'h0003, 2);
        run_op("sll4",    16'h00FF, 4'd4,  2'b01, 16'h0FF0, 5);
        run_op("srl15",   16'h8000, 4'd15, 2'b11, 16'h0001, 16);
        run_op("ror15",   16'h0001, 4'd15, 2'b10, 16'h0002, 16);
        run_op("ror0",    16'hA5A5, 4'd0,  2'b10, 16'hA5A5, 1);
        run_op("srl_mix", 16'hF00F, 4'd3,  2'b11, 16'h1E01, 4);

        // backpressure: result held while out_ready is low and in_* toggle
        launch(16'h00FF, 4'd4, 2'b01, lat);
        check("bp.latency", lat, 5);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1111 * 16'(i + 1);
            in_cnt   = 4'(i);
            in_op    = 2'(i);
            tick();
            check("bp.out_valid", out_valid, 1'b1);
            check("bp.out_data",  out_data,  16'h0FF0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle("bp.release", 16'h0FF0);

        // abort in IDLE beats a simultaneous request
        in_valid = 1'b1;
        in_data  = 16'h5555;
        in_cnt   = 4'd2;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check_idle("abort_idle", 16'h0FF0);

        // abort on the 3rd SHIFT cycle of a cnt=8 operation
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_cnt   = 4'd8;
        in_op    = 2'b00;
        tick();
        in_valid = 1'b0;
        seen_valid = out_valid;
        tick();
        seen_valid |= out_valid;
        tick();
        seen_valid |= out_valid;
        check("abort.in_shift", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.in_ready", in_ready, 1'b1);
        check("abort.busy",     busy,     1'b0);
        for (int i = 0; i < 10; i++) begin
            seen_valid |= out_valid;
            tick();
        end
        check("abort.never_valid", seen_valid, 1'b0);
        run_op("post_abort", 16'h0001, 4'd2, 2'b01, 16'h0004, 3);

        // reset in the middle of SHIFT
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_cnt   = 4'd10;
        in_op    = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rst_shift.busy_before", busy, 1'b1);
        do_reset();
        check_idle("rst_shift", 16'h0000);
        run_op("post_rst_shift", 16'hF000, 4'd4, 2'b11, 16'h0F00, 5);

        // reset while holding a result in DONE
        launch(16'h0003, 4'd1, 2'b01, lat);
        check("rst_done.out_data_before", out_data, 16'h0006);
        do_reset();
        check_idle("rst_done", 16'h0000);
        run_op("post_rst_done", 16'h8000, 4'd1, 2'b00, 16'h0001, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
